// File: rtl/pc_gen_unit.sv
// pc_gen_unit
//   Program-counter stage of the STRV32I core. Holds the architectural PC,
//   selects the next fetch address (trap > buffered redirect > branch > +4),
//   buffers one redirect that arrives while the instruction bus is stalled,
//   flags misaligned branch/jump targets and pulses a one-cycle flush after
//   any applied redirect.
//
// Ports
//   clk_in               core clock, rising edge
//   rst_in               synchronous active-high reset
//   branch_taken_in      branch/JAL/JALR redirect request
//   jalr_in              current instruction is JALR (clear target bit 0)
//   iadder_in[31:0]      branch/jump target from the immediate adder
//   trap_taken_in        trap/interrupt/MRET redirect request
//   trap_address_in      trap vector or EPC
//   ahb_ready_in         instruction bus ready (0 = stall)
//   pc_out               registered PC of the current instruction
//   pc_plus_4_out        pc_out + 4 (link value)
//   next_pc_out          combinational fetch address
//   i_addr_valid_out     registered fetch-address valid
//   flush_out            registered one-cycle squash of the fetched instruction
//   misaligned_instr_out combinational: taken redirect to a non-word target

module pc_gen_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        branch_taken_in,
    input  logic        jalr_in,
    input  logic [31:0] iadder_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        ahb_ready_in,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus_4_out,
    output logic [31:0] next_pc_out,
    output logic        i_addr_valid_out,
    output logic        flush_out,
    output logic        misaligned_instr_out
);

    typedef enum logic {
        S_RESET = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        flush_q, flush_d;
    logic        addr_valid_q, addr_valid_d;

    logic [31:0] br_target;
    logic        misaligned;
    logic        branch_ok;
    logic        redirect;
    logic [31:0] next_pc;

    always_comb begin
        br_target  = jalr_in ? {iadder_in[31:1], 1'b0} : iadder_in;
        misaligned = (state_q == S_RUN) & branch_taken_in & br_target[1];
        // A misaligned branch is dropped here; the trap unit raises the
        // exception and redirects through trap_taken_in.
        branch_ok  = branch_taken_in & ~misaligned;

        state_d          = state_q;
        pc_d             = pc_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        flush_d          = 1'b0;
        addr_valid_d     = addr_valid_q;
        redirect         = 1'b0;
        next_pc          = pc_q;

        if (state_q == S_RESET) begin
            // Redirect inputs are ignored until the first fetch is issued.
            next_pc         = RESET_VECTOR;
            pc_d            = RESET_VECTOR;
            pending_valid_d = 1'b0;
            addr_valid_d    = 1'b1;
            state_d         = S_RUN;
        end else begin
            addr_valid_d = 1'b1;
            if (ahb_ready_in) begin
                if (trap_taken_in) begin
                    next_pc  = trap_address_in;
                    redirect = 1'b1;
                end else if (pending_valid_q) begin
                    next_pc  = pending_target_q;
                    redirect = 1'b1;
                end else if (branch_ok) begin
                    next_pc  = br_target;
                    redirect = 1'b1;
                end else begin
                    next_pc = pc_q + 32'd4;
                end
                pc_d            = next_pc;
                pending_valid_d = 1'b0;
                flush_d         = redirect;
            end else begin
                // Stalled: PC holds. The fetch address only reflects a
                // redirect once it has been captured in the pending slot.
                next_pc = pending_valid_q ? pending_target_q : pc_q;
                if (trap_taken_in) begin
                    // A trap replaces whatever was buffered.
                    pending_target_d = trap_address_in;
                    pending_valid_d  = 1'b1;
                end else if (branch_ok && !pending_valid_q) begin
                    // The first buffered branch is the oldest; later ones
                    // belong to the wrong path and are discarded.
                    pending_target_d = br_target;
                    pending_valid_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q          <= S_RESET;
            pc_q             <= RESET_VECTOR;
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'h0;
            flush_q          <= 1'b1;
            addr_valid_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
            flush_q          <= flush_d;
            addr_valid_q     <= addr_valid_d;
        end
    end

    assign pc_out               = pc_q;
    assign pc_plus_4_out        = pc_q + 32'd4;
    assign next_pc_out          = next_pc;
    assign i_addr_valid_out     = addr_valid_q;
    assign flush_out            = flush_q;
    assign misaligned_instr_out = misaligned;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Testbench for pc_gen_unit: directed scenarios with constant expectations,
// then a randomized run checked against a queue-based reference model.

module tb_pc_gen_unit;

    localparam logic [31:0] RV = 32'h0000_0100;

    logic        clk_in;
    logic        rst_in;
    logic        branch_taken_in;
    logic        jalr_in;
    logic [31:0] iadder_in;
    logic        trap_taken_in;
    logic [31:0] trap_address_in;
    logic        ahb_ready_in;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] next_pc_out;
    logic        i_addr_valid_out;
    logic        flush_out;
    logic        misaligned_instr_out;

    int n_cmp = 0;
    int n_err = 0;

    pc_gen_unit #(.RESET_VECTOR(RV)) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .branch_taken_in      (branch_taken_in),
        .jalr_in              (jalr_in),
        .iadder_in            (iadder_in),
        .trap_taken_in        (trap_taken_in),
        .trap_address_in      (trap_address_in),
        .ahb_ready_in         (ahb_ready_in),
        .pc_out               (pc_out),
        .pc_plus_4_out        (pc_plus_4_out),
        .next_pc_out          (next_pc_out),
        .i_addr_valid_out     (i_addr_valid_out),
        .flush_out            (flush_out),
        .misaligned_instr_out (misaligned_instr_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    // Architectural view: "running" flag, PC, a FIFO of at most one buffered
    // redirect, and the last flush/valid values.
    bit          m_run   = 1'b0;
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_pq[$];
    bit          m_flush = 1'b1;
    bit          m_valid = 1'b0;

    function automatic logic [31:0] m_tgt();
        return jalr_in ? (iadder_in & 32'hFFFF_FFFE) : iadder_in;
    endfunction

    function automatic bit m_mis();
        logic [31:0] t;
        t = m_tgt();
        return m_run && branch_taken_in && (t % 4 >= 2);
    endfunction

    function automatic bit m_branch_go();
        return branch_taken_in && !m_mis();
    endfunction

    function automatic logic [31:0] m_next();
        if (!m_run) return RV;
        if (!ahb_ready_in) return (m_pq.size() > 0) ? m_pq[0] : m_pc;
        if (trap_taken_in) return trap_address_in;
        if (m_pq.size() > 0) return m_pq[0];
        if (m_branch_go()) return m_tgt();
        return m_pc + 32'd4;
    endfunction

    task automatic model_edge();
        logic [31:0] nxt;
        bit          redir;
        nxt   = m_next();
        redir = trap_taken_in || (m_pq.size() > 0) || m_branch_go();
        if (rst_in) begin
            m_run = 0; m_pc = RV; m_pq.delete(); m_flush = 1; m_valid = 0;
        end else if (!m_run) begin
            m_run = 1; m_pc = RV; m_pq.delete(); m_flush = 0; m_valid = 1;
        end else if (ahb_ready_in) begin
            m_flush = redir; m_pc = nxt; m_pq.delete();
        end else begin
            m_flush = 0;
            if (trap_taken_in) begin
                m_pq.delete(); m_pq.push_back(trap_address_in);
            end else if (m_branch_go() && m_pq.size() == 0) begin
                m_pq.push_back(m_tgt());
            end
        end
    endtask

    // Advance one clock: model follows the inputs present at the edge,
    // outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        model_edge();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        rst_in = 0; branch_taken_in = 0; jalr_in = 0; iadder_in = 0;
        trap_taken_in = 0; trap_address_in = 0; ahb_ready_in = 1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        rst_in = 1; branch_taken_in = 1; iadder_in = 32'h20A;
        tick(); tick();
        n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc_out, 32'h100); end
        n_cmp++; if (flush_out !== 1'b1) begin n_err++; $display("FAIL reset_flush: got %b want 1", flush_out); end
        n_cmp++; if (i_addr_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", i_addr_valid_out); end
        n_cmp++; if (misaligned_instr_out !== 1'b0) begin n_err++; $display("FAIL reset_mis: got %b want 0", misaligned_instr_out); end
        n_cmp++; if (next_pc_out !== 32'h100) begin n_err++; $display("FAIL reset_next: got %h want %h", next_pc_out, 32'h100); end
        idle_inputs();
        tick();
        n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL run_entry_pc: got %h want %h", pc_out, 32'h100); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL run_entry_flush: got %b want 0", flush_out); end
        n_cmp++; if (i_addr_valid_out !== 1'b1) begin n_err++; $display("FAIL run_entry_valid: got %b want 1", i_addr_valid_out); end
        tick();
        n_cmp++; if (pc_out !== 32'h104) begin n_err++; $display("FAIL seq_pc1: got %h want %h", pc_out, 32'h104); end
        tick();
        n_cmp++; if (pc_out !== 32'h108) begin n_err++; $display("FAIL seq_pc2: got %h want %h", pc_out, 32'h108); end
        n_cmp++; if (pc_plus_4_out !== 32'h10C) begin n_err++; $display("FAIL seq_pc4: got %h want %h", pc_plus_4_out, 32'h10C); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL seq_flush: got %b want 0", flush_out); end
    endtask

    task automatic test_branch();
        idle_inputs();
        trap_taken_in = 1; trap_address_in = 32'h200;
        tick();
        n_cmp++; if (pc_out !== 32'h200) begin n_err++; $display("FAIL trap_setup_pc: got %h want %h", pc_out, 32'h200); end
        idle_inputs();
        branch_taken_in = 1; iadder_in = 32'h180;
        #1;
        n_cmp++; if (next_pc_out !== 32'h180) begin n_err++; $display("FAIL br_next: got %h want %h", next_pc_out, 32'h180); end
        tick();
        n_cmp++; if (pc_out !== 32'h180) begin n_err++; $display("FAIL br_pc: got %h want %h", pc_out, 32'h180); end
        n_cmp++; if (flush_out !== 1'b1) begin n_err++; $display("FAIL br_flush: got %b want 1", flush_out); end
        idle_inputs();
        tick();
        n_cmp++; if (pc_out !== 32'h184) begin n_err++; $display("FAIL br_after_pc: got %h want %h", pc_out, 32'h184); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL br_after_flush: got %b want 0", flush_out); end
    endtask

    task automatic test_jalr();
        idle_inputs();
        branch_taken_in = 1; jalr_in = 1; iadder_in = 32'h305;
        #1;
        n_cmp++; if (misaligned_instr_out !== 1'b0) begin n_err++; $display("FAIL jalr_mis: got %b want 0", misaligned_instr_out); end
        tick();
        n_cmp++; if (pc_out !== 32'h304) begin n_err++; $display("FAIL jalr_pc: got %h want %h", pc_out, 32'h304); end
        n_cmp++; if (pc_plus_4_out !== 32'h308) begin n_err++; $display("FAIL jalr_pc4: got %h want %h", pc_plus_4_out, 32'h308); end
    endtask

    task automatic test_misaligned();
        idle_inputs();
        branch_taken_in = 1; iadder_in = 32'h20A;
        #1;
        n_cmp++; if (misaligned_instr_out !== 1'b1) begin n_err++; $display("FAIL mis_flag: got %b want 1", misaligned_instr_out); end
        n_cmp++; if (next_pc_out !== 32'h308) begin n_err++; $display("FAIL mis_next: got %h want %h", next_pc_out, 32'h308); end
        tick();
        n_cmp++; if (pc_out !== 32'h308) begin n_err++; $display("FAIL mis_pc: got %h want %h", pc_out, 32'h308); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL mis_flush: got %b want 0", flush_out); end
    endtask

    // Three stall cycles with two branches, optionally a trap in the third.
    task automatic test_stall(input bit with_trap, input logic [31:0] want);
        logic [31:0] pc0;
        pc0 = pc_out;
        idle_inputs(); ahb_ready_in = 0; branch_taken_in = 1; iadder_in = 32'h400;
        tick();
        idle_inputs(); ahb_ready_in = 0; branch_taken_in = 1; iadder_in = 32'h500;
        #1;
        n_cmp++; if (next_pc_out !== 32'h400) begin n_err++; $display("FAIL stall_next1: got %h want %h", next_pc_out, 32'h400); end
        n_cmp++; if (pc_out !== pc0) begin n_err++; $display("FAIL stall_hold1: got %h want %h", pc_out, pc0); end
        tick();
        idle_inputs(); ahb_ready_in = 0;
        if (with_trap) begin trap_taken_in = 1; trap_address_in = 32'h800; end
        tick();
        n_cmp++; if (pc_out !== pc0) begin n_err++; $display("FAIL stall_hold3: got %h want %h", pc_out, pc0); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL stall_flush: got %b want 0", flush_out); end
        idle_inputs();
        #1;
        n_cmp++; if (next_pc_out !== want) begin n_err++; $display("FAIL stall_next3: got %h want %h", next_pc_out, want); end
        tick();
        n_cmp++; if (pc_out !== want) begin n_err++; $display("FAIL stall_release_pc: got %h want %h", pc_out, want); end
        n_cmp++; if (flush_out !== 1'b1) begin n_err++; $display("FAIL stall_release_flush: got %b want 1", flush_out); end
        tick();
        n_cmp++; if (pc_out !== want + 32'd4) begin n_err++; $display("FAIL stall_after_pc: got %h want %h", pc_out, want + 32'd4); end
    endtask

    task automatic test_simultaneous();
        idle_inputs();
        trap_taken_in = 1; trap_address_in = 32'h1C0; branch_taken_in = 1; iadder_in = 32'h40;
        tick();
        n_cmp++; if (pc_out !== 32'h1C0) begin n_err++; $display("FAIL simul_pc: got %h want %h", pc_out, 32'h1C0); end
        n_cmp++; if (flush_out !== 1'b1) begin n_err++; $display("FAIL simul_flush: got %b want 1", flush_out); end
    endtask

    task automatic test_wrap();
        idle_inputs();
        trap_taken_in = 1; trap_address_in = 32'hFFFF_FFFC;
        tick();
        n_cmp++; if (pc_plus_4_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want 0", pc_plus_4_out); end
        idle_inputs();
        tick();
        n_cmp++; if (pc_out !== 32'h0) begin n_err++; $display("FAIL wrap_pc: got %h want 0", pc_out); end
        n_cmp++; if (flush_out !== 1'b0 || misaligned_instr_out !== 1'b0) begin n_err++; $display("FAIL wrap_flags: got flush %b mis %b want 0 0", flush_out, misaligned_instr_out); end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs(); ahb_ready_in = 0; branch_taken_in = 1; iadder_in = 32'h600;
        tick();
        idle_inputs(); ahb_ready_in = 0; rst_in = 1;
        tick();
        n_cmp++; if (pc_out !== RV || flush_out !== 1'b1 || i_addr_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_stall: got pc %h fl %b v %b want %h 1 0", pc_out, flush_out, i_addr_valid_out, RV); end
        idle_inputs();
        tick();
        tick();
        n_cmp++; if (pc_out !== RV + 32'd4) begin n_err++; $display("FAIL rst_stall_discard: got %h want %h", pc_out, RV + 32'd4); end
        n_cmp++; if (flush_out !== 1'b0) begin n_err++; $display("FAIL rst_stall_flush: got %b want 0", flush_out); end
    endtask

    task automatic test_random();
        logic [31:0] e_next;
        bit          e_mis;
        for (int i = 0; i < 400; i++) begin
            rst_in          = ($urandom_range(0, 59) == 0);
            ahb_ready_in    = ($urandom_range(0, 3) != 0);
            branch_taken_in = ($urandom_range(0, 3) == 0);
            jalr_in         = $urandom_range(0, 1);
            iadder_in       = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) iadder_in = iadder_in | $urandom_range(1, 3);
            trap_taken_in   = ($urandom_range(0, 9) == 0);
            trap_address_in = $urandom & 32'hFFFF_FFFC;
            #1;
            e_next = m_next();
            e_mis  = m_mis();
            n_cmp++; if (next_pc_out !== e_next) begin n_err++; $display("FAIL rnd_next[%0d]: got %h want %h", i, next_pc_out, e_next); end
            n_cmp++; if (misaligned_instr_out !== e_mis) begin n_err++; $display("FAIL rnd_mis[%0d]: got %b want %b", i, misaligned_instr_out, e_mis); end
            tick();
            n_cmp++; if (pc_out !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc_out, m_pc); end
            n_cmp++; if (pc_plus_4_out !== m_pc + 32'd4) begin n_err++; $display("FAIL rnd_pc4[%0d]: got %h want %h", i, pc_plus_4_out, m_pc + 32'd4); end
            n_cmp++; if (flush_out !== m_flush) begin n_err++; $display("FAIL rnd_flush[%0d]: got %b want %b", i, flush_out, m_flush); end
            n_cmp++; if (i_addr_valid_out !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, i_addr_valid_out, m_valid); end
        end
    endtask

    initial begin
        idle_inputs();
        @(posedge clk_in);
        #1;
        test_reset();
        test_branch();
        test_jalr();
        test_misaligned();
        test_stall(1'b0, 32'h400);
        test_stall(1'b1, 32'h800);
        test_simultaneous();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
